// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, the run-state encoding and a window helper.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;
  localparam int unsigned V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-clock divider: one-clk p_tick every DIV clks while enabled (DIV 1..16).
module vga_tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic p_tick
);

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

  logic [3:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 4'd1;
    end
  end

  // Gating by en keeps the strobe low during reset even when DIV==1.
  assign p_tick = en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters, registered active-low syncs, video_on.
// Define VGA_SYNC_FRAME_TICK_EN to enable the frame_tick strobe (tied low otherwise).
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int unsigned DIV       = 4,
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DISP = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_DISP = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  run_state_e       state;
  logic             run;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;

  assign run = (state == ST_RUN);

  vga_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run),
    .p_tick  (p_tick)
  );

  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (p_tick) begin
      if (h_count == H_LAST) begin
        h_next = '0;
        v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
      end else begin
        h_next = h_count + 10'd1;
      end
    end
  end

  // Syncs are decoded from the next counts so they change on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_HALT;
      h_count <= '0;
      v_count <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      state   <= ST_RUN;
      h_count <= h_next;
      v_count <= v_next;
      hsync   <= !in_window(h_next, HS_LO, HS_HI);
      vsync   <= !in_window(v_next, VS_LO, VS_HI);
    end
  end

  assign pixel_x  = h_count;
  assign pixel_y  = v_count;
  assign video_on = run && (h_count < H_DISP) && (v_count < V_DISP);

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic frame_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= p_tick && (h_count == H_LAST) && (v_count == V_LAST);
    end
  end

  assign frame_tick = frame_q;
`else
  assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default-timing vector table plus reduced-timing frame sequences.
module tb_vga_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic       pt_a, pt_b, pt_c;
  logic [9:0] px_a, px_b, px_c, py_a, py_b, py_c;
  logic       von_a, von_b, von_c, hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, ft_a, ft_b, ft_c;

  vga_sync u_a (
    .clk(clk), .reset_n(rst_a), .p_tick(pt_a), .pixel_x(px_a), .pixel_y(py_a),
    .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
  );

  // Small raster: 16 x 12 total, 8 x 6 visible, hsync 10..12, vsync 7..8.
  vga_sync #(
    .DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
  ) u_b (
    .clk(clk), .reset_n(rst_b), .p_tick(pt_b), .pixel_x(px_b), .pixel_y(py_b),
    .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
  );

  vga_sync #(
    .DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
  ) u_c (
    .clk(clk), .reset_n(rst_c), .p_tick(pt_c), .pixel_x(px_c), .pixel_y(py_c),
    .video_on(von_c), .hsync(hs_c), .vsync(vs_c), .frame_tick(ft_c)
  );

  typedef struct {
    logic        rst;
    int unsigned clks;
    logic        pt;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        hs;
    logic        vs;
    logic        von;
    logic        ft;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

`ifdef VGA_SYNC_FRAME_TICK_EN
  localparam bit FT_EN = 1'b1;
`else
  localparam bit FT_EN = 1'b0;
`endif

  function automatic logic [31:0] pk(input logic pt, input logic [9:0] px, input logic [9:0] py,
                                     input logic hs, input logic vs, input logic von, input logic ft);
    return {7'd0, pt, px, py, hs, vs, von, ft};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h (pt,px,py,hs,vs,von,ft) expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input int unsigned clks, input logic pt,
                     input int unsigned px, input int unsigned py,
                     input logic hs, input logic vs, input logic von);
    vec_t v;
    v.rst = rst; v.clks = clks; v.pt = pt; v.px = 10'(px); v.py = 10'(py);
    v.hs = hs; v.vs = vs; v.von = von; v.ft = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned bad, c_von, c_vs, c_hs, c_ft, c_tick, t, h, v;
    logic e_pt, e_hs, e_vs, e_von, e_ft;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // rst, clks, p_tick, x, y, hsync, vsync, video_on
    add(0, 1,    0,   0, 0, 1, 1, 0);
    add(1, 1,    0,   0, 0, 1, 1, 1);
    add(1, 2,    0,   0, 0, 1, 1, 1);
    add(1, 1,    1,   0, 0, 1, 1, 1);
    add(1, 1,    0,   1, 0, 1, 1, 1);
    add(1, 3,    1,   1, 0, 1, 1, 1);
    add(1, 1,    0,   2, 0, 1, 1, 1);
    add(1, 2548, 0, 639, 0, 1, 1, 1);
    add(1, 4,    0, 640, 0, 1, 1, 0);
    add(1, 60,   0, 655, 0, 1, 1, 0);
    add(1, 3,    1, 655, 0, 1, 1, 0);
    add(1, 1,    0, 656, 0, 0, 1, 0);
    add(1, 380,  0, 751, 0, 0, 1, 0);
    add(1, 4,    0, 752, 0, 1, 1, 0);
    add(1, 188,  0, 799, 0, 1, 1, 0);
    add(1, 4,    0,   0, 1, 1, 1, 1);
    add(1, 2800, 0, 700, 1, 0, 1, 0);
    add(0, 1,    0,   0, 0, 1, 1, 0);
    add(1, 1,    0,   0, 0, 1, 1, 1);
    add(1, 3,    1,   0, 0, 1, 1, 1);
    add(1, 1,    0,   1, 0, 1, 1, 1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rst;
      repeat (vecs[i].clks) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), pk(pt_a, px_a, py_a, hs_a, vs_a, von_a, ft_a),
          pk(vecs[i].pt, vecs[i].px, vecs[i].py, vecs[i].hs, vecs[i].vs, vecs[i].von, vecs[i].ft));
    end

    // Two full small frames at DIV=2 plus one edge to catch the second wrap.
    chk("b_reset", pk(pt_b, px_b, py_b, hs_b, vs_b, von_b, ft_b), pk(0, 0, 0, 1, 1, 0, 0));
    rst_b = 1'b1;
    bad = 0; c_von = 0; c_vs = 0; c_hs = 0; c_ft = 0; c_tick = 0;
    for (int unsigned e = 1; e <= 769; e++) begin
      cyc();
      t = (e - 1) / 2;
      h = t % 16;
      v = (t / 16) % 12;
      e_pt  = ((e - 1) % 2) == 1;
      e_hs  = !(h >= 10 && h <= 12);
      e_vs  = !(v >= 7 && v <= 8);
      e_von = (h < 8) && (v < 6);
      e_ft  = FT_EN && (t > 0) && (t % 192 == 0) && ((e - 1) % 2 == 0);
      if (pk(pt_b, px_b, py_b, hs_b, vs_b, von_b, ft_b) !== pk(e_pt, 10'(h), 10'(v), e_hs, e_vs, e_von, e_ft))
        bad++;
      if (pt_b) begin
        c_tick++;
        if (von_b) c_von++;
        if (!vs_b) c_vs++;
        if (!hs_b) c_hs++;
      end
      if (ft_b) c_ft++;
    end
    chk("b_model_mismatch_samples", bad, 0);
    chk("b_tick_count", c_tick, 384);
    chk("b_video_on_ticks", c_von, 96);
    chk("b_vsync_low_ticks", c_vs, 64);
    chk("b_hsync_low_ticks", c_hs, 72);
    chk("b_frame_tick_count", c_ft, FT_EN ? 2 : 0);

    // Reset while both syncs are low must release them on the next edge.
    rst_b = 1'b0;
    cyc();
    rst_b = 1'b1;
    repeat (279) cyc();
    chk("b_in_sync_window", pk(pt_b, px_b, py_b, hs_b, vs_b, von_b, ft_b), pk(0, 11, 8, 0, 0, 0, 0));
    rst_b = 1'b0;
    cyc();
    chk("b_midframe_reset", pk(pt_b, px_b, py_b, hs_b, vs_b, von_b, ft_b), pk(0, 0, 0, 1, 1, 0, 0));
    rst_b = 1'b1;
    cyc();
    chk("b_restart_edge1", pk(pt_b, px_b, py_b, hs_b, vs_b, von_b, ft_b), pk(0, 0, 0, 1, 1, 1, 0));
    cyc();
    chk("b_restart_edge2", pk(pt_b, px_b, py_b, hs_b, vs_b, von_b, ft_b), pk(1, 0, 0, 1, 1, 1, 0));

    // DIV=1: tick every clk after release, 192-clk frame.
    chk("c_reset", pk(pt_c, px_c, py_c, hs_c, vs_c, von_c, ft_c), pk(0, 0, 0, 1, 1, 0, 0));
    rst_c = 1'b1;
    bad = 0; c_ft = 0; c_tick = 0;
    for (int unsigned e = 1; e <= 200; e++) begin
      cyc();
      t = e - 1;
      h = t % 16;
      v = (t / 16) % 12;
      e_ft = FT_EN && (t > 0) && (t % 192 == 0);
      if (pk(pt_c, px_c, py_c, hs_c, vs_c, von_c, ft_c) !==
          pk(1, 10'(h), 10'(v), !(h >= 10 && h <= 12), !(v >= 7 && v <= 8), (h < 8) && (v < 6), e_ft))
        bad++;
      if (pt_c) c_tick++;
      if (ft_c) c_ft++;
      if (e == 192) chk("c_last_pixel", {12'd0, px_c, py_c}, {12'd0, 10'd15, 10'd11});
      if (e == 193) chk("c_frame_wrap", {12'd0, px_c, py_c}, 32'd0);
    end
    chk("c_model_mismatch_samples", bad, 0);
    chk("c_tick_every_clk", c_tick, 200);
    chk("c_frame_tick_count", c_ft, FT_EN ? 1 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
